tank_decoder_param: RTL and testbench
=====================================

// Module: tank_decoder_param
// PURPOSE
//  Parametrised store-tank decoder for the control section. Routes one serial
//  word window between a register and one of NUM_TANKS delay-line tanks (each
//  split into down/up halves). Read gates the selected tank output onto the
//  register input (mob). Write breaks the selected tank's recirculation and
//  feeds mib into it. Adds a double-word mode (down then up, back to back)
//  plus busy/done/err status.
// PARAMETERS
//  NUM_TANKS  4   number of tanks; each tank has a down half and an up half
//  SEL_W      2   tank_sel width, >= $clog2(NUM_TANKS)
//  WORD_BITS  18  bit-times in one short-word window
// PORTS
//  clk        in   1            system clock, one bit-time per cycle
//  rst_neg    in   1            asynchronous active-low reset
//  f9_pos     in   1            word-window start pulse, 1 cycle wide
//  read       in   1            request: tank -> register
//  write      in   1            request: register -> tank
//  dbl        in   1            double-word request; ignores half_sel
//  tank_sel   in   SEL_W        tank number
//  half_sel   in   1            0 = down half, 1 = up half
//  mob_t      in   2*NUM_TANKS  tank serial outputs, index {tank,half}
//  mib        in   1            serial data from register (write)
//  r_shift    out  1            register shift enable during transfer
//  r_mob      out  1            serial data to register (read)
//  t_in       out  2*NUM_TANKS  serial data into tanks (write)
//  t_clr      out  2*NUM_TANKS  recirculation break per tank half (write)
//  busy       out  1            request accepted, not yet done
//  done       out  1            1-cycle pulse after the last bit
//  err        out  1            1-cycle pulse on a rejected request
// BEHAVIOUR
//  Reset: state IDLE, bit counter 0, every output 0, latched request cleared.
//  Reset is honoured mid-transfer: the transfer is aborted with no done pulse.
//  Handshake: in IDLE, a request is accepted when read^write is 1. The block
//   latches op, dbl, tank_sel, half_sel and asserts busy on the next cycle.
//  Rejects: read&write, or tank_sel >= NUM_TANKS -> err pulse; stay IDLE.
//   While busy, all request inputs are ignored; no err is raised.
//  FSM:
//   IDLE  -> ARMED  on accept
//   ARMED -> XFER   on f9_pos. f9_pos in the accept cycle itself is ignored.
//   XFER  counts WORD_BITS cycles (cnt 0..WORD_BITS-1).
//    At cnt==WORD_BITS-1: if dbl and current half=down -> XFER2 (cnt=0, half=up,
//    no f9 wait); else -> DONE.
//   XFER2 works like XFER for the up half; at cnt==WORD_BITS-1 -> DONE.
//   DONE  -> IDLE; done=1 for this cycle; busy drops in the same cycle.
//   f9_pos seen during XFER/XFER2/DONE is ignored.
//  Datapath: all outputs are registered; idx = {latched tank, current half}.
//   In XFER/XFER2: r_shift=1.
//    Read: r_mob = mob_t[idx] sampled the previous cycle (1-cycle latency).
//    Write: t_clr[idx]=1; t_in[idx]=mib from the previous cycle.
//   All other bits of t_in/t_clr, and r_mob on write, are 0.
//   The transfer occupies exactly WORD_BITS cycles (2*WORD_BITS when dbl).
//  Counter: $clog2(WORD_BITS) bits. It wraps to 0 at the window end; it never
//   reaches WORD_BITS.
// TESTING
//  1 Read t2 up: read=1,tank_sel=2,half=1, then f9 -> r_shift 18 cycles;
//    r_mob = mob_t[5] delayed 1; done once; t_clr all 0.
//  2 Write t0 down with mib=1010..: f9 -> t_clr[0]=1 for 18 cycles;
//    t_in[0] copies the mib pattern delayed 1; other lanes 0.
//  3 Double read t3 (dbl=1, half=1): down then up -> 36 contiguous r_shift
//    cycles, idx 6 then 7, a single done.
//  4 read&write together, and tank_sel=4 with NUM_TANKS=4 -> err pulse each;
//    busy stays 0; no t_clr.
//  5 rst_neg low at cnt=9 of a write -> all outputs 0 asynchronously; no done;
//    next request works.
//  6 Second request and f9_pos injected mid-XFER -> ignored; counts unchanged.
//    Regress with NUM_TANKS=8, SEL_W=3, WORD_BITS=35.

Source files
------------

// File: rtl/tank_decoder_param.sv
// Store-tank decoder: moves one serial word window between the register and a
// selected tank half, with an optional double-word (down then up) transfer.
module tank_decoder_param #(
    parameter int unsigned NUM_TANKS = 4,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned WORD_BITS = 18
) (
    input  logic                   clk,
    input  logic                   rst_neg,
    input  logic                   f9_pos,
    input  logic                   read,
    input  logic                   write,
    input  logic                   dbl,
    input  logic [SEL_W-1:0]       tank_sel,
    input  logic                   half_sel,
    input  logic [2*NUM_TANKS-1:0] mob_t,
    input  logic                   mib,
    output logic                   r_shift,
    output logic                   r_mob,
    output logic [2*NUM_TANKS-1:0] t_in,
    output logic [2*NUM_TANKS-1:0] t_clr,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned LANES = 2 * NUM_TANKS;
    localparam int unsigned CNT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int unsigned IDX_W = SEL_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_XFER  = 3'd2,
        S_XFER2 = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_wr_q, op_wr_d;
    logic               dbl_q, dbl_d;
    logic [SEL_W-1:0]   tank_q, tank_d;
    logic               half_q, half_d;

    logic               r_shift_d, r_mob_d, busy_d, done_d, err_d;
    logic [LANES-1:0]   t_in_d, t_clr_d;
    logic               shift_d;
    logic [IDX_W-1:0]   idx_d;
    logic               sel_bad;

    // Tank number out of range; only possible when the select field can encode it.
    if ((1 << SEL_W) > NUM_TANKS) begin : g_sel_chk
        assign sel_bad = (32'(tank_sel) >= NUM_TANKS);
    end else begin : g_sel_ok
        assign sel_bad = 1'b0;
    end

    // Next-state: request handshake, window sequencing and bit counting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        dbl_d   = dbl_q;
        tank_d  = tank_q;
        half_d  = half_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (read | write) begin
                    if ((read & write) | sel_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_ARMED;
                        op_wr_d = write;
                        dbl_d   = dbl;
                        tank_d  = tank_sel;
                        half_d  = dbl ? 1'b0 : half_sel;
                    end
                end
            end
            S_ARMED: begin
                if (f9_pos) begin
                    state_d = S_XFER;
                    cnt_d   = '0;
                end
            end
            S_XFER, S_XFER2: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if ((state_q == S_XFER) && dbl_q && !half_q) begin
                        state_d = S_XFER2;
                        half_d  = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output is a plain register.
    always_comb begin
        shift_d   = (state_d == S_XFER) || (state_d == S_XFER2);
        idx_d     = {tank_d, half_d};
        r_shift_d = shift_d;
        busy_d    = (state_d == S_ARMED) || shift_d;
        done_d    = (state_d == S_DONE);
        r_mob_d   = 1'b0;
        t_in_d    = '0;
        t_clr_d   = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (shift_d && (32'(idx_d) == i)) begin
                if (op_wr_d) begin
                    t_clr_d[i] = 1'b1;
                    t_in_d[i]  = mib;
                end else begin
                    r_mob_d = mob_t[i];
                end
            end
        end
    end

    // State, latched request and output registers.
    always_ff @(posedge clk or negedge rst_neg) begin
        if (!rst_neg) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            dbl_q   <= 1'b0;
            tank_q  <= '0;
            half_q  <= 1'b0;
            r_shift <= 1'b0;
            r_mob   <= 1'b0;
            t_in    <= '0;
            t_clr   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            dbl_q   <= dbl_d;
            tank_q  <= tank_d;
            half_q  <= half_d;
            r_shift <= r_shift_d;
            r_mob   <= r_mob_d;
            t_in    <= t_in_d;
            t_clr   <= t_clr_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_tank_decoder_param.sv
// Bench for tank_decoder_param: table of requests, per-cycle expected outputs
// queued as stimulus is driven and compared one cycle later.
module tb_tank_decoder_param;

    localparam int unsigned NT = 4;
    localparam int unsigned SW = 3;
    localparam int unsigned WB = 18;
    localparam int unsigned LN = 2 * NT;

    logic          clk = 1'b0;
    logic          rst_neg;
    logic          f9_pos, read, write, dbl, half_sel, mib;
    logic [SW-1:0] tank_sel;
    logic [LN-1:0] mob_t;
    logic          r_shift, r_mob, busy, done, err;
    logic [LN-1:0] t_in, t_clr;

    tank_decoder_param #(.NUM_TANKS(NT), .SEL_W(SW), .WORD_BITS(WB)) dut (
        .clk      (clk),
        .rst_neg  (rst_neg),
        .f9_pos   (f9_pos),
        .read     (read),
        .write    (write),
        .dbl      (dbl),
        .tank_sel (tank_sel),
        .half_sel (half_sel),
        .mob_t    (mob_t),
        .mib      (mib),
        .r_shift  (r_shift),
        .r_mob    (r_mob),
        .t_in     (t_in),
        .t_clr    (t_clr),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          err;
        logic          r_shift;
        logic          r_mob;
        logic [LN-1:0] t_in;
        logic [LN-1:0] t_clr;
    } exp_t;

    // Request record: inputs plus whether a reject (err) is expected.
    typedef struct {
        logic          rd;
        logic          wr;
        logic          dbl;
        logic [SW-1:0] tank;
        logic          half;
        logic          f9_acc;
        logic          bad;
        int            inject_at;
        int            abort_at;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm);
        exp_t a;
        exp_t e;
        a = '{busy: busy, done: done, err: err, r_shift: r_shift,
              r_mob: r_mob, t_in: t_in, t_clr: t_clr};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %h", nm, a);
        end else begin
            e = sb.pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", nm, a, e);
            end
        end
    endtask

    task automatic cyc(input exp_t e, input string nm);
        sb.push_back(e);
        @(posedge clk);
        #1;
        chk(nm);
    endtask

    task automatic clear_req();
        read     = 1'b0;
        write    = 1'b0;
        dbl      = 1'b0;
        tank_sel = '0;
        half_sel = 1'b0;
        f9_pos   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        exp_t e;
        int   nbits;
        int   idx;
        logic hf;
        read     = v.rd;
        write    = v.wr;
        dbl      = v.dbl;
        tank_sel = v.tank;
        half_sel = v.half;
        f9_pos   = v.f9_acc;
        e = '0;
        if (v.bad) e.err = 1'b1;
        else       e.busy = 1'b1;
        cyc(e, $sformatf("v%0d accept", vi));
        clear_req();
        if (v.bad) begin
            e = '0;
            cyc(e, $sformatf("v%0d after reject", vi));
            return;
        end
        e = '0;
        e.busy = 1'b1;
        cyc(e, $sformatf("v%0d armed", vi));
        nbits = v.dbl ? int'(2 * WB) : int'(WB);
        for (int n = 0; n < nbits; n++) begin
            f9_pos   = (n == 0) || (n == v.inject_at);
            read     = (n == v.inject_at);
            tank_sel = (n == v.inject_at) ? SW'(1) : SW'(0);
            mob_t    = LN'($urandom);
            mib      = (n % 2 == 0);
            hf       = v.dbl ? (n >= int'(WB)) : v.half;
            idx      = 2 * int'(v.tank) + int'(hf);
            e = '0;
            e.busy    = 1'b1;
            e.r_shift = 1'b1;
            if (v.wr) begin
                e.t_clr[idx] = 1'b1;
                e.t_in[idx]  = mib;
            end else begin
                e.r_mob = mob_t[idx];
            end
            cyc(e, $sformatf("v%0d bit%0d", vi, n));
            if (n == v.abort_at) begin
                rst_neg = 1'b0;
                #1;
                e = '0;
                sb.push_back(e);
                chk($sformatf("v%0d async reset", vi));
                clear_req();
                @(negedge clk);
                rst_neg = 1'b1;
                e = '0;
                cyc(e, $sformatf("v%0d post reset", vi));
                e = '0;
                cyc(e, $sformatf("v%0d no done after reset", vi));
                return;
            end
        end
        clear_req();
        mob_t = LN'($urandom);
        e = '0;
        e.done = 1'b1;
        cyc(e, $sformatf("v%0d done", vi));
        e = '0;
        cyc(e, $sformatf("v%0d idle", vi));
    endtask

    vec_t vecs[10];

    initial begin
        exp_t e;
        //           rd    wr    dbl   tank  half  f9acc bad   inj abort
        vecs[0] = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, -1, -1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, -1, -1};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, -1, -1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, -1, -1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, -1, -1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, -1,  9};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0,  5, -1};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 20, -1};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 3'd7, 1'b1, 1'b0, 1'b1, -1, -1};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, -1, -1};

        rst_neg = 1'b0;
        clear_req();
        mob_t = '0;
        mib   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        e = '0;
        sb.push_back(e);
        chk("reset state");
        rst_neg = 1'b1;
        e = '0;
        cyc(e, "idle after reset");

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
        end

        // Busy ignores a fresh request in the DONE cycle and in ARMED.
        read = 1'b1; tank_sel = SW'(2);
        e = '0; e.busy = 1'b1;
        cyc(e, "seq accept");
        read = 1'b1; write = 1'b1; tank_sel = SW'(6);
        e = '0; e.busy = 1'b1;
        cyc(e, "seq bad request while armed");
        clear_req();
        for (int n = 0; n < int'(WB); n++) begin
            f9_pos = (n == 0);
            mob_t  = LN'($urandom);
            e = '0; e.busy = 1'b1; e.r_shift = 1'b1; e.r_mob = mob_t[4];
            cyc(e, $sformatf("seq bit%0d", n));
        end
        f9_pos = 1'b0;
        write = 1'b1; tank_sel = SW'(3);
        e = '0; e.done = 1'b1;
        cyc(e, "seq done");
        clear_req();
        e = '0;
        cyc(e, "seq idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
